// File: rtl/issue_sched_ctrl.sv
// issue_sched_ctrl: dual-slot issue scheduler with long-latency scoreboard, in-flight counter and privileged serialisation FSM.
// Define ISSUE_DUAL_EN to allow slot1 co-issue; otherwise the block is single-issue.
module issue_sched_ctrl #(
  parameter int NREG = 32,
  parameter int INFL_W = 4
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              flush,
  input  logic [1:0]        in_valid,
  input  logic [4:0]        in_rd0,
  input  logic [4:0]        in_rd1,
  input  logic [4:0]        in_rj0,
  input  logic [4:0]        in_rj1,
  input  logic [4:0]        in_rk0,
  input  logic [4:0]        in_rk1,
  input  logic [1:0]        in_we,
  input  logic [1:0]        in_long,
  input  logic [1:0]        in_priv,
  input  logic              out_ready,
  input  logic [1:0]        wb_valid,
  input  logic [4:0]        wb_rd0,
  input  logic [4:0]        wb_rd1,
  input  logic [1:0]        retire_cnt,
  input  logic              priv_done,
  output logic [1:0]        issue_valid,
  output logic [1:0]        in_take,
  output logic [NREG-1:0]   busy_vec,
  output logic [1:0]        sched_state,
  output logic [INFL_W-1:0] inflight
);
  typedef enum logic [1:0] {NORM = 2'd0, DRAIN = 2'd1, PWAIT = 2'd2} state_t;
  localparam logic [INFL_W:0] MAX = (INFL_W+1)'((1 << INFL_W) - 1);
  state_t state, state_n;
  logic v0, h0, cap0, drained, pair1;
  logic [1:0] issue;
  logic [INFL_W:0] sum;
  logic [INFL_W-1:0] inflight_n;
  logic [NREG-1:0] set, clr, busy_n;
  // r0 is never busy, so the register-0 checks fall out of the scoreboard itself
  assign v0 = in_valid[0] & rstn;
  assign h0 = busy_vec[in_rj0] | busy_vec[in_rk0] | (in_we[0] & busy_vec[in_rd0]);
  assign cap0 = ({1'b0, inflight} + (INFL_W+1)'(1)) <= MAX;
  assign drained = INFL_W'(retire_cnt) >= inflight;
`ifdef ISSUE_DUAL_EN
  logic v1, h1, cap1;
  assign v1 = in_valid[1] & rstn;
  assign cap1 = ({1'b0, inflight} + (INFL_W+1)'(2)) <= MAX;
  assign h1 = busy_vec[in_rj1] | busy_vec[in_rk1] | (in_we[1] & busy_vec[in_rd1])
    | (in_we[0] & (in_rd0 != 5'd0) & ((in_rd0 == in_rj1) | (in_rd0 == in_rk1) | (in_we[1] & (in_rd0 == in_rd1))))
    | (in_long[0] & in_long[1]);
  assign pair1 = v1 & ~in_priv[1] & ~h1 & cap1;
`else
  logic unused_slot1;
  assign unused_slot1 = ^{in_valid[1], in_rj1, in_rk1, in_priv[1]};
  assign pair1 = 1'b0;
`endif
  always_comb begin
    issue = 2'b00;
    state_n = state;
    case (state)
      NORM: if (v0 & in_priv[0]) begin
        issue[0] = (inflight == '0) & out_ready;
        state_n = (inflight != '0) ? DRAIN : out_ready ? PWAIT : NORM;
      end else begin
        issue[0] = v0 & ~h0 & out_ready & cap0;
        issue[1] = issue[0] & pair1;
      end
      DRAIN: begin
        issue[0] = v0 & drained & out_ready;
        state_n = issue[0] ? PWAIT : DRAIN;
      end
      PWAIT: state_n = priv_done ? NORM : PWAIT;
      default: state_n = NORM;
    endcase
    if (flush) begin
      issue = 2'b00;
      state_n = NORM;
    end
  end
  // a new long-latency set beats a writeback clear of the same register
  always_comb begin
    set = '0;
    clr = '0;
    if (issue[0] & in_we[0] & in_long[0]) set[in_rd0] = 1'b1;
    if (issue[1] & in_we[1] & in_long[1]) set[in_rd1] = 1'b1;
    if (wb_valid[0]) clr[wb_rd0] = 1'b1;
    if (wb_valid[1]) clr[wb_rd1] = 1'b1;
    busy_n = (busy_vec & ~clr) | set;
    busy_n[0] = 1'b0;
  end
  assign sum = {1'b0, inflight} + (INFL_W+1)'(issue[0]) + (INFL_W+1)'(issue[1]);
  assign inflight_n = (sum < (INFL_W+1)'(retire_cnt)) ? '0 : INFL_W'(sum - (INFL_W+1)'(retire_cnt));
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) begin
      state <= NORM;
      busy_vec <= '0;
      inflight <= '0;
    end else if (flush) begin
      state <= NORM;
      busy_vec <= '0;
      inflight <= '0;
    end else begin
      state <= state_n;
      busy_vec <= busy_n;
      inflight <= inflight_n;
    end
  assign issue_valid = issue;
  assign in_take = issue;
  assign sched_state = state;
  retire_le_inflight: assert property (@(posedge clk) disable iff (!rstn || flush) (INFL_W+1)'(retire_cnt) <= sum);
endmodule

// File: tb/tb_issue_sched_ctrl.sv
// tb_issue_sched_ctrl: directed stimulus pushes expected per-cycle results; a monitor pops and compares.
module tb_issue_sched_ctrl;
`ifdef ISSUE_DUAL_EN
  localparam int D = 1;
`else
  localparam int D = 0;
`endif
  localparam logic [1:0] PV = (D == 1) ? 2'b11 : 2'b01;
  localparam logic [3:0] PI = (D == 1) ? 4'd2 : 4'd1;
  logic clk = 1'b0, rstn = 1'b0, flush, out_ready, priv_done;
  logic [1:0] in_valid, in_we, in_long, in_priv, wb_valid, retire_cnt;
  logic [4:0] in_rd0, in_rd1, in_rj0, in_rj1, in_rk0, in_rk1, wb_rd0, wb_rd1;
  logic [1:0] issue_valid, in_take, sched_state;
  logic [31:0] busy_vec;
  logic [3:0] inflight;
  typedef struct {
    logic [1:0] iv;
    logic [1:0] st;
    logic [3:0] inf;
    logic [31:0] busy;
    int id;
  } rec_t;
  rec_t q[$];
  int n_cmp = 0, n_bad = 0, n_id = 0;

  issue_sched_ctrl dut (
    .clk(clk), .rstn(rstn), .flush(flush), .in_valid(in_valid),
    .in_rd0(in_rd0), .in_rd1(in_rd1), .in_rj0(in_rj0), .in_rj1(in_rj1),
    .in_rk0(in_rk0), .in_rk1(in_rk1), .in_we(in_we), .in_long(in_long),
    .in_priv(in_priv), .out_ready(out_ready), .wb_valid(wb_valid),
    .wb_rd0(wb_rd0), .wb_rd1(wb_rd1), .retire_cnt(retire_cnt),
    .priv_done(priv_done), .issue_valid(issue_valid), .in_take(in_take),
    .busy_vec(busy_vec), .sched_state(sched_state), .inflight(inflight)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input int id, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s step%0d got %h want %h", nm, id, act, exp);
    end
  endtask

  task automatic clr_in();
    in_valid = 2'b00; in_we = 2'b00; in_long = 2'b00; in_priv = 2'b00;
    in_rd0 = 5'd0; in_rd1 = 5'd0; in_rj0 = 5'd0; in_rj1 = 5'd0; in_rk0 = 5'd0; in_rk1 = 5'd0;
    out_ready = 1'b1; flush = 1'b0; wb_valid = 2'b00; wb_rd0 = 5'd0; wb_rd1 = 5'd0;
    retire_cnt = 2'd0; priv_done = 1'b0;
  endtask

  task automatic nx();
    @(negedge clk);
    clr_in();
  endtask

  task automatic pair_ok();
    in_valid = 2'b11; in_we = 2'b11;
    in_rd0 = 5'd5; in_rd1 = 5'd6; in_rj0 = 5'd1; in_rk0 = 5'd2; in_rj1 = 5'd3; in_rk1 = 5'd4;
  endtask

  task automatic one(input logic [4:0] rd, input logic [4:0] rj, input logic lng, input logic prv);
    in_valid = 2'b01; in_we = {1'b0, rd != 5'd0}; in_rd0 = rd; in_rj0 = rj; in_rk0 = 5'd2;
    in_long = {1'b0, lng}; in_priv = {1'b0, prv};
  endtask

  task automatic push(input logic [1:0] iv, input logic [1:0] st, input logic [3:0] inf, input logic [31:0] busy);
    rec_t r;
    n_id++;
    r.iv = iv; r.st = st; r.inf = inf; r.busy = busy; r.id = n_id;
    q.push_back(r);
  endtask

  initial begin
    rec_t r;
    forever begin
      @(negedge clk);
      #3;
      if (q.size() != 0) begin
        r = q.pop_front();
        chk("issue_valid", r.id, 32'(issue_valid), 32'(r.iv));
        chk("in_take", r.id, 32'(in_take), 32'(r.iv));
        @(posedge clk);
        #1;
        chk("sched_state", r.id, 32'(sched_state), 32'(r.st));
        chk("inflight", r.id, 32'(inflight), 32'(r.inf));
        chk("busy_vec", r.id, busy_vec, r.busy);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    clr_in();
    pair_ok();
    #3;
    chk("rst_issue", 0, 32'(issue_valid), 32'd0);
    chk("rst_take", 0, 32'(in_take), 32'd0);
    chk("rst_busy", 0, busy_vec, 32'd0);
    chk("rst_inflight", 0, 32'(inflight), 32'd0);
    chk("rst_state", 0, 32'(sched_state), 32'd0);
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    clr_in();
    // independent pair
    nx(); pair_ok(); push(PV, 2'd0, PI, 32'h0);
    nx(); retire_cnt = PI[1:0]; push(2'b00, 2'd0, 4'd0, 32'h0);
    // RAW inside the pair, then the leftover as slot0
    nx(); pair_ok(); in_rj1 = 5'd5; push(2'b01, 2'd0, 4'd1, 32'h0);
    nx(); one(5'd6, 5'd5, 1'b0, 1'b0); push(2'b01, 2'd0, 4'd2, 32'h0);
    nx(); retire_cnt = 2'd2; push(2'b00, 2'd0, 4'd0, 32'h0);
    // load r7, dependent stall, writeback, same-cycle set and clear
    nx(); one(5'd7, 5'd1, 1'b1, 1'b0); push(2'b01, 2'd0, 4'd1, 32'h80);
    nx(); one(5'd8, 5'd7, 1'b0, 1'b0); push(2'b00, 2'd0, 4'd1, 32'h80);
    nx(); one(5'd8, 5'd7, 1'b0, 1'b0); wb_valid = 2'b01; wb_rd0 = 5'd7; push(2'b00, 2'd0, 4'd1, 32'h0);
    nx(); one(5'd8, 5'd7, 1'b0, 1'b0); push(2'b01, 2'd0, 4'd2, 32'h0);
    nx(); one(5'd7, 5'd1, 1'b1, 1'b0); wb_valid = 2'b01; wb_rd0 = 5'd7; push(2'b01, 2'd0, 4'd3, 32'h80);
    nx(); wb_valid = 2'b10; wb_rd1 = 5'd7; push(2'b00, 2'd0, 4'd3, 32'h0);
    nx(); pair_ok(); in_rd0 = 5'd9; in_rd1 = 5'd10; in_long = 2'b11; push(2'b01, 2'd0, 4'd4, 32'h200);
    // privileged serialisation
    nx(); out_ready = 1'b0; retire_cnt = 2'd1; push(2'b00, 2'd0, 4'd3, 32'h200);
    nx(); one(5'd0, 5'd0, 1'b0, 1'b1); push(2'b00, 2'd1, 4'd3, 32'h200);
    nx(); one(5'd0, 5'd0, 1'b0, 1'b1); push(2'b00, 2'd1, 4'd3, 32'h200);
    nx(); one(5'd0, 5'd0, 1'b0, 1'b1); out_ready = 1'b0; retire_cnt = 2'd2; push(2'b00, 2'd1, 4'd1, 32'h200);
    nx(); one(5'd0, 5'd0, 1'b0, 1'b1); out_ready = 1'b0; retire_cnt = 2'd1; push(2'b00, 2'd1, 4'd0, 32'h200);
    nx(); one(5'd0, 5'd0, 1'b0, 1'b1); push(2'b01, 2'd2, 4'd1, 32'h200);
    nx(); one(5'd11, 5'd1, 1'b0, 1'b0); push(2'b00, 2'd2, 4'd1, 32'h200);
    nx(); one(5'd11, 5'd1, 1'b0, 1'b0); priv_done = 1'b1; push(2'b00, 2'd0, 4'd1, 32'h200);
    nx(); one(5'd11, 5'd1, 1'b0, 1'b0); push(2'b01, 2'd0, 4'd2, 32'h200);
    // flush while waiting for a privileged commit
    nx(); one(5'd0, 5'd0, 1'b0, 1'b1); push(2'b00, 2'd1, 4'd2, 32'h200);
    nx(); one(5'd0, 5'd0, 1'b0, 1'b1); out_ready = 1'b0; retire_cnt = 2'd2; push(2'b00, 2'd1, 4'd0, 32'h200);
    nx(); one(5'd0, 5'd0, 1'b0, 1'b1); push(2'b01, 2'd2, 4'd1, 32'h200);
    nx(); one(5'd11, 5'd1, 1'b0, 1'b0); flush = 1'b1; push(2'b00, 2'd0, 4'd0, 32'h0);
    // capacity limit
    for (int i = 1; i <= ((D == 1) ? 7 : 14); i++) begin
      nx(); pair_ok(); push(PV, 2'd0, 4'(i * ((D == 1) ? 2 : 1)), 32'h0);
    end
    nx(); pair_ok(); push(2'b01, 2'd0, 4'd15, 32'h0);
    nx(); pair_ok(); push(2'b00, 2'd0, 4'd15, 32'h0);
    nx(); pair_ok(); retire_cnt = 2'd1; push(2'b00, 2'd0, 4'd14, 32'h0);
    nx(); pair_ok(); push(2'b01, 2'd0, 4'd15, 32'h0);
    nx(); pair_ok(); flush = 1'b1; push(2'b00, 2'd0, 4'd0, 32'h0);
    nx(); pair_ok(); push(PV, 2'd0, PI, 32'h0);
    nx();
    repeat (3) @(negedge clk);
    chk("queue_drained", 0, 32'(q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
